pcs_scrambler_64b: RTL and testbench

//  - Transmit-side 64b/66b PCS scrambler, self-synchronous g(x) = x^58 + x^39 + 1; inverse of Descrambler_64bit.
//  - Scrambles each 64-bit payload LSB first; the 2-bit sync header passes through unscrambled and aligned with its payload.
//  - Sits between the 64b/66b encoder and the gearbox; one-stage registered pipeline with valid/ready on both sides.

---
 rtl/pcs_scrambler_64b.sv | 150 +++++++++++++++
 tb/tb_pcs_scrambler_64b.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_scrambler_64b.sv
// pcs_scrambler_64b
// Transmit-side 64b/66b PCS scrambler, self-synchronous g(x) = x^58 + x^39 + 1.
// The payload is scrambled LSB first (bit 0 is first on the wire); the sync
// header passes through untouched and stays aligned with its payload.
// One registered pipeline stage with valid/ready on both sides.
//
// Optional feature macro: PCS_SCRAMBLER_BYPASS_EN
//   When defined, a `bypass` input is added. A beat accepted with bypass=1 is
//   emitted unscrambled, but the LFSR still advances using the raw data as
//   the line bit, so the far-end descrambler stays locked when bypass ends.
//
// Handshake: a beat moves on a rising edge where valid && ready are both high.
// in_ready = !out_valid || out_ready, so the single output register can be
// refilled in the same cycle it is drained. A beat already accepted is never
// dropped, and out_data/out_hdr hold steady while out_valid && !out_ready.

module pcs_scrambler_64b #(
   parameter int          DATA_WIDTH = 64,
   parameter int          HDR_WIDTH  = 2,
   parameter logic [57:0] SEED_INIT  = 58'h3FF_FFFF_FFFF_FFFF,
   parameter int          CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [HDR_WIDTH-1:0]  in_hdr,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [HDR_WIDTH-1:0]  out_hdr,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  seed_load,
   input  logic [57:0]           seed_value,
`ifdef PCS_SCRAMBLER_BYPASS_EN
   input  logic                  bypass,
`endif
   output logic [CNT_WIDTH-1:0]  blk_cnt,
   input  logic                  blk_cnt_clr
);

   // Only the two lane widths used by the PCS are supported.
   generate
      if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
         $error("pcs_scrambler_64b: DATA_WIDTH must be 32 or 64");
      end
   endgenerate

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   // Registered state. state_q[0] is the most recently emitted line bit.
   logic [57:0]           state_q,     state_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [HDR_WIDTH-1:0]  out_hdr_q,   out_hdr_d;
   logic                  out_valid_q, out_valid_d;
   logic [CNT_WIDTH-1:0]  blk_cnt_q,   blk_cnt_d;

   // Combinational scrambler results for the beat currently on in_data.
   logic [DATA_WIDTH-1:0] scr_data;
   logic [57:0]           scr_state;
   logic                  scr_bit;
   logic                  byp_sel;
   logic                  accept;

`ifdef PCS_SCRAMBLER_BYPASS_EN
   assign byp_sel = bypass;
`else
   assign byp_sel = 1'b0;
`endif

   // The output register can take a new beat when empty or being drained.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Unrolled bit-serial scrambler: one full beat per cycle from state_q.
   // The line bit fed back into the LFSR is whatever goes on the wire for a
   // scrambled beat, or the raw data bit for a bypassed beat.
   always_comb begin
      scr_state = state_q;
      scr_data  = '0;
      scr_bit   = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         scr_bit     = in_data[i] ^ scr_state[38] ^ scr_state[57];
         scr_data[i] = byp_sel ? in_data[i] : scr_bit;
         scr_state   = {scr_state[56:0], scr_data[i]};
      end
   end

   // LFSR next state: advance on an accepted beat; a seed load overrides the
   // post-beat value, but the beat itself was already scrambled with the old
   // state above.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = scr_state;
      end
      if (seed_load) begin
         state_d = seed_value;
      end
   end

   // Output register: load on accept, empty when drained without refill,
   // otherwise hold (covers stalls).
   always_comb begin
      out_data_d  = out_data_q;
      out_hdr_d   = out_hdr_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_data_d  = scr_data;
         out_hdr_d   = in_hdr;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Accepted-beat counter: saturates at all-ones, clear has priority.
   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (blk_cnt_clr) begin
         blk_cnt_d = '0;
      end else if (accept && (blk_cnt_q != CNT_MAX)) begin
         blk_cnt_d = blk_cnt_q + CNT_WIDTH'(1);
      end
   end

   // All flops share one synchronous reset; a beat presented during reset
   // is dropped because the reset branch ignores the next-state values.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= SEED_INIT;
         out_data_q  <= '0;
         out_hdr_q   <= '0;
         out_valid_q <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_hdr_q   <= out_hdr_d;
         out_valid_q <= out_valid_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_hdr   = out_hdr_q;
   assign out_valid = out_valid_q;
   assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_pcs_scrambler_64b.sv
// tb_pcs_scrambler_64b
// Randomized bench for pcs_scrambler_64b. The reference model treats the line
// as a time series of bits: o[n] = d[n] ^ o[n-39] ^ o[n-58], kept as a bit
// history queue. A second instance with CNT_WIDTH=4 exercises counter
// saturation. Optional feature macro: PCS_SCRAMBLER_BYPASS_EN.

module tb_pcs_scrambler_64b;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic [1:0]  in_hdr = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        seed_load = 1'b0;
   logic [57:0] seed_value = '0;
   logic        blk_cnt_clr = 1'b0;
   logic        bypass = 1'b0;

   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [1:0]  out_hdr;
   logic [31:0] blk_cnt;

   logic        in_ready4, out_valid4;
   logic [63:0] out_data4;
   logic [1:0]  out_hdr4;
   logic [3:0]  blk_cnt4;

   pcs_scrambler_64b #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CNT_WIDTH(32)) u_dut (
      .CLK(CLK), .rst(rst), .in_data(in_data), .in_hdr(in_hdr),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_hdr(out_hdr), .out_valid(out_valid), .out_ready(out_ready),
      .seed_load(seed_load), .seed_value(seed_value),
`ifdef PCS_SCRAMBLER_BYPASS_EN
      .bypass(bypass),
`endif
      .blk_cnt(blk_cnt), .blk_cnt_clr(blk_cnt_clr)
   );

   pcs_scrambler_64b #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CNT_WIDTH(4)) u_dut4 (
      .CLK(CLK), .rst(rst), .in_data(in_data), .in_hdr(in_hdr),
      .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
      .out_hdr(out_hdr4), .out_valid(out_valid4), .out_ready(out_ready),
      .seed_load(seed_load), .seed_value(seed_value),
`ifdef PCS_SCRAMBLER_BYPASS_EN
      .bypass(bypass),
`endif
      .blk_cnt(blk_cnt4), .blk_cnt_clr(blk_cnt_clr)
   );

   // ---------------- scoreboard / model ----------------
   // exp_q entry: {raw payload[63:0], hdr[1:0], scrambled payload[63:0]}
   logic [129:0] exp_q[$];
   logic [129:0] last_e;
   bit           hist[$];      // scrambler line-bit history, oldest first
   bit           dhist[$];     // far-end descrambler history
   logic [31:0]  m_cnt;
   logic [3:0]   m_cnt4;
   int           n_vec = 0;
   int           n_fail = 0;
   int           n_acc = 0;
   bit           dsc_en = 0;
   int           dsc_n = 0;

   task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic hist_from_seed(input logic [57:0] s);
      hist.delete();
      for (int k = 57; k >= 0; k--) hist.push_back(s[k]);
   endtask

   task automatic model_reset();
      hist_from_seed(58'h3FF_FFFF_FFFF_FFFF);
      exp_q.delete();
      last_e = '0;
      m_cnt  = '0;
      m_cnt4 = '0;
   endtask

   // Line bit n depends on bits n-39 and n-58 already on the wire.
   task automatic model_beat(input logic [63:0] d, input bit byp, output logic [63:0] o);
      for (int i = 0; i < 64; i++) begin
         bit b;
         b = d[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
         o[i] = byp ? d[i] : b;
         hist.push_back(o[i]);
         void'(hist.pop_front());
      end
   endtask

   task automatic descramble(input logic [63:0] o, output logic [63:0] d);
      for (int i = 0; i < 64; i++) begin
         d[i] = o[i] ^ dhist[dhist.size()-39] ^ dhist[dhist.size()-58];
         dhist.push_back(o[i]);
         void'(dhist.pop_front());
      end
   endtask

   // ---------------- driver ----------------
   // One clock: drive inputs after the falling edge, check what the last
   // rising edge produced, then predict the effect of the coming edge.
   task automatic cycle(input logic r, input logic v, input logic [63:0] d,
                        input logic [1:0] h, input logic ordy, input logic sl,
                        input logic [57:0] sv, input logic clr, input logic byp);
      logic [129:0] e;
      logic [63:0]  so, rec;
      logic         acc, cons;
      bit           eb;
`ifdef PCS_SCRAMBLER_BYPASS_EN
      eb = byp;
`else
      eb = 1'b0;
`endif
      @(negedge CLK);
      rst = r; in_valid = v; in_data = d; in_hdr = h; out_ready = ordy;
      seed_load = sl; seed_value = sv; blk_cnt_clr = clr; bypass = byp;
      #1;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
      e = (exp_q.size() != 0) ? exp_q[0] : last_e;
      check("out_word", {out_hdr, out_data}, e[65:0]);
      check("blk_cnt", blk_cnt, m_cnt);
      check("blk_cnt4", blk_cnt4, m_cnt4);

      acc  = v && ((exp_q.size() == 0) || ordy);
      cons = (exp_q.size() != 0) && ordy;
      if (r) begin
         model_reset();
      end else begin
         if (cons) begin
            e = exp_q.pop_front();
            if (dsc_en) begin
               descramble(e[63:0], rec);
               if (dsc_n >= 1) check("descrambled", rec, e[129:66]);
               dsc_n++;
            end
         end
         if (acc) begin
            model_beat(d, eb, so);
            e = {d, h, so};
            exp_q.push_back(e);
            last_e = e;
            n_acc++;
         end
         if (sl) hist_from_seed(sv);
         if (clr) begin
            m_cnt = '0; m_cnt4 = '0;
         end else if (acc) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 != 4'hF) m_cnt4++;
         end
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 1'b0, 64'h0, 2'b00, ordy, 1'b0, 58'h0, 1'b0, 1'b0);
   endtask

   task automatic beat(input logic [63:0] d, input logic [1:0] h, input logic ordy);
      cycle(1'b0, 1'b1, d, h, ordy, 1'b0, 58'h0, 1'b0, 1'b0);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int start_acc, guard;
      // 1. reset held 3 cycles, then released
      @(posedge CLK);
      model_reset();
      cycle(1'b1, 1'b1, 64'hDEAD, 2'b10, 1'b1, 1'b0, 58'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 58'h0, 1'b0, 1'b0);
      idle(1'b1);
      check("rst_out_data", out_data, 64'h0);
      check("rst_in_ready", in_ready, 1'b1);

      // 2. zero seed keeps an all-zero payload at zero
      cycle(1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 58'h0, 1'b0, 1'b0);
      beat(64'h0, 2'b01, 1'b1);
      beat(64'h0, 2'b10, 1'b1);
      check("seed0_data", out_data, 64'h0);
      check("seed0_hdr", out_hdr, 2'b01);
      idle(1'b1);
      check("seed0_data2", out_data, 64'h0);
      idle(1'b1);

      // 3. 1000 random beats from SEED_INIT, looped through a descrambler
      cycle(1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 58'h0, 1'b0, 1'b0);
      dhist.delete();
      for (int k = 0; k < 58; k++) dhist.push_back(1'b0);
      dsc_en = 1; dsc_n = 0;
      start_acc = n_acc; guard = 0;
      while ((n_acc - start_acc) < 1000 && guard < 4000) begin
         beat_or_gap: begin
            logic v, ordy;
            v    = ($urandom_range(0, 9) != 0);
            ordy = (guard < 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cycle(1'b0, v, rnd64(), 2'($urandom_range(1, 2)), ordy, 1'b0, 58'h0, 1'b0, 1'b0);
         end
         guard++;
      end
      check("beats_1000", n_acc - start_acc, 1000);
      idle(1'b1);
      idle(1'b1);
      dsc_en = 0;

      // 4. five-cycle stall with a beat pending and another offered
      beat(rnd64(), 2'b01, 1'b0);
      for (int k = 0; k < 5; k++) beat(rnd64(), 2'b10, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      for (int k = 0; k < 4; k++) beat(rnd64(), 2'b01, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // 5. seed load coincident with an accepted beat
      cycle(1'b0, 1'b1, rnd64(), 2'b01, 1'b1, 1'b1, 58'h1, 1'b0, 1'b0);
      beat(rnd64(), 2'b10, 1'b1);
      beat(rnd64(), 2'b01, 1'b1);
      idle(1'b1);

      // 6. counter saturation (4-bit instance) and clear vs increment
      cycle(1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 58'h0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) beat(rnd64(), 2'b01, 1'b1);
      idle(1'b1);
      check("cnt4_sat", blk_cnt4, 4'hF);
      check("cnt_20", blk_cnt, 32'd20);
      cycle(1'b0, 1'b1, rnd64(), 2'b10, 1'b1, 1'b0, 58'h0, 1'b1, 1'b0);
      idle(1'b1);
      check("cnt_clr", blk_cnt, 32'd0);
      check("cnt4_clr", blk_cnt4, 4'h0);

      // bypass beats then a scrambled beat (bypass ignored when not built in)
      beat(rnd64(), 2'b01, 1'b1);
      cycle(1'b0, 1'b1, rnd64(), 2'b01, 1'b1, 1'b0, 58'h0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, rnd64(), 2'b10, 1'b1, 1'b0, 58'h0, 1'b0, 1'b1);
      beat(rnd64(), 2'b01, 1'b1);
      idle(1'b1);

      // 7. everything random, including seeds, clears and short resets
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rnd64(),
               2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0, {26'($urandom()), 32'($urandom())},
               $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      end
      idle(1'b1);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
